// File: rtl/sm_step_gen.sv
// Stepper pulse generator: turns move commands into step/dir/enable with a linear
// accel/decel period ramp, absolute position tracking, limit and enable aborts.
module sm_step_gen #(
  parameter int STEP_HIGH    = 50,
  parameter int DIR_SETUP    = 25,
  parameter int PERIOD_START = 5000,
  parameter int PERIOD_MIN   = 1000,
  parameter int PERIOD_DEC   = 100,
  parameter int POS_W        = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_enable_SM,
  input  logic                    move_req,
  input  logic                    move_dir,
  input  logic [15:0]             move_steps,
  input  logic                    limit_fwd,
  input  logic                    limit_rev,
  output logic                    sm_step,
  output logic                    sm_dir,
  output logic                    sm_en,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic signed [POS_W-1:0] position
);

  // state | meaning
  // IDLE  | waiting for a command, driver disabled
  // SETUP | dir/en valid, counting setup time before first step
  // HIGH  | step pulse high
  // LOW   | remainder of the step period; ramp decision at its end
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_M1   = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] HIGH_M1    = CNT_W'(STEP_HIGH - 1);
  localparam logic [CNT_W-1:0] HIGH_P1    = CNT_W'(STEP_HIGH + 1);
  localparam logic [CNT_W-1:0] P_START    = CNT_W'(PERIOD_START);
  localparam logic [CNT_W-1:0] P_MIN      = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_DEC      = CNT_W'(PERIOD_DEC);
  localparam logic [CNT_W-1:0] P_DEC_TOP  = CNT_W'(PERIOD_START - PERIOD_DEC);
  localparam logic [CNT_W-1:0] P_ACC_BOT  = CNT_W'(PERIOD_MIN + PERIOD_DEC);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [15:0]      remaining;
  logic [15:0]      ramp_cnt;
  logic             abort;

  // sm_dir doubles as the latched move direction while busy
  assign abort = (state != IDLE) &&
                 (!drv_enable_SM || (sm_dir ? limit_fwd : limit_rev));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      period    <= '0;
      remaining <= '0;
      ramp_cnt  <= '0;
      sm_step   <= 1'b0;
      sm_dir    <= 1'b0;
      sm_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      position  <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        sm_step <= 1'b0;
        sm_en   <= 1'b0;
        busy    <= 1'b0;
        fault   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (move_req && drv_enable_SM) begin
              if (move_steps == '0) begin
                done <= 1'b1;
              end else if (move_dir ? limit_fwd : limit_rev) begin
                fault <= 1'b1;
              end else begin
                sm_dir    <= move_dir;
                remaining <= move_steps;
                period    <= P_START;
                ramp_cnt  <= '0;
                sm_en     <= 1'b1;
                busy      <= 1'b1;
                cnt       <= SETUP_M1;
                state     <= SETUP;
              end
            end
          end
          SETUP: begin
            if (cnt == '0) begin
              sm_step   <= 1'b1;
              cnt       <= HIGH_M1;
              remaining <= remaining - 16'd1;
              position  <= sm_dir ? position + POS_W'(1) : position - POS_W'(1);
              state     <= HIGH;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              sm_step <= 1'b0;
              cnt     <= period - HIGH_P1;
              state   <= LOW;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LOW: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
              sm_en <= 1'b0;
            end else begin
              // ramp_cnt counts accel steps taken, so decel mirrors accel
              if (remaining <= ramp_cnt) begin
                period   <= (period >= P_DEC_TOP) ? P_START : period + P_DEC;
                ramp_cnt <= ramp_cnt - 16'd1;
              end else if (period > P_MIN) begin
                period   <= (period <= P_ACC_BOT) ? P_MIN : period - P_DEC;
                ramp_cnt <= ramp_cnt + 16'd1;
              end
              sm_step   <= 1'b1;
              cnt       <= HIGH_M1;
              remaining <= remaining - 16'd1;
              position  <= sm_dir ? position + POS_W'(1) : position - POS_W'(1);
              state     <= HIGH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_step_gen.sv
// Directed bench for sm_step_gen: vector table of whole moves plus hand-written
// abort, reset and command corner-case sequences.
module tb_sm_step_gen;

  logic        clk = 1'b0;
  logic        rst, drv_enable_SM, move_req, move_dir, limit_fwd, limit_rev;
  logic [15:0] move_steps;
  logic        sm_step, sm_dir, sm_en, busy, done, fault;
  logic signed [23:0] position;

  sm_step_gen #(
    .STEP_HIGH(2), .DIR_SETUP(3), .PERIOD_START(20),
    .PERIOD_MIN(10), .PERIOD_DEC(5), .POS_W(24)
  ) dut (
    .clk(clk), .rst(rst), .drv_enable_SM(drv_enable_SM), .move_req(move_req),
    .move_dir(move_dir), .move_steps(move_steps), .limit_fwd(limit_fwd),
    .limit_rev(limit_rev), .sm_step(sm_step), .sm_dir(sm_dir), .sm_en(sm_en),
    .busy(busy), .done(done), .fault(fault), .position(position)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int n_rise, done_cyc, fault_cyc, both_hi;
  int rise_cyc [16];
  logic busy_at1, en_at1, dir_at1, step_end, busy_end, en_end, dir_end;

  typedef struct packed {
    logic        do_rst;
    logic        dir;
    logic [15:0] steps;
    logic [7:0]  np;
    logic [15:0] first;
    logic [15:0] last;
    logic [15:0] done_c;
    logic [23:0] pos;
  } vec_t;

  vec_t vecs [7];
  int   exp6 [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pos_u();
    return int'({8'd0, position});
  endfunction

  // Cycle 0 is the cycle move_req is presented; cycle c is sampled 1 time unit
  // after the c-th following rising edge.
  task automatic run_move(input logic dir, input logic [15:0] steps,
                          input int abort_kind, input int busy_req_at,
                          input int budget);
    logic prev;
    n_rise = 0; done_cyc = -1; fault_cyc = -1; both_hi = 0;
    step_end = 1'b1; busy_end = 1'b1; en_end = 1'b1; dir_end = 1'b0;
    move_dir = dir; move_steps = steps; move_req = 1'b1;
    prev = sm_step;
    for (int c = 1; c <= budget; c++) begin
      tick();
      move_req = 1'b0;
      if (c == busy_req_at) begin
        move_req = 1'b1; move_dir = ~dir; move_steps = 16'd5;
      end
      if (c == 1) begin
        busy_at1 = busy; en_at1 = sm_en; dir_at1 = sm_dir;
      end
      if (sm_step && !prev) begin
        if (n_rise < 16) rise_cyc[n_rise] = c;
        n_rise++;
        if (abort_kind == 1 && n_rise == 2) limit_fwd = 1'b1;
        if (abort_kind == 2 && n_rise == 2) drv_enable_SM = 1'b0;
      end
      prev = sm_step;
      if (done && fault) both_hi = 1;
      if (done && done_cyc < 0) done_cyc = c;
      if (fault && fault_cyc < 0) fault_cyc = c;
      if (done_cyc >= 0 || fault_cyc >= 0) begin
        step_end = sm_step; busy_end = busy; en_end = sm_en; dir_end = sm_dir;
        break;
      end
    end
    move_req = 1'b0;
  endtask

  task automatic watch_idle(input int n, output int rises, output int act);
    logic prev;
    rises = 0; act = 0; prev = sm_step;
    for (int c = 0; c < n; c++) begin
      tick();
      if (sm_step && !prev) rises++;
      if (busy || sm_en || done || fault) act++;
      prev = sm_step;
    end
  endtask

  int r, a;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'd1, 8'd1, 16'd4, 16'd4,  16'd24, 24'd1};
    vecs[1] = '{1'b1, 1'b1, 16'd6, 8'd6, 16'd4, 16'd74, 16'd94, 24'd6};
    vecs[2] = '{1'b0, 1'b0, 16'd3, 8'd3, 16'd4, 16'd39, 16'd59, 24'd3};
    vecs[3] = '{1'b1, 1'b0, 16'd1, 8'd1, 16'd4, 16'd4,  16'd24, 24'hFFFFFF};
    vecs[4] = '{1'b1, 1'b1, 16'd2, 8'd2, 16'd4, 16'd24, 16'd39, 24'd2};
    vecs[5] = '{1'b0, 1'b1, 16'd4, 8'd4, 16'd4, 16'd49, 16'd64, 24'd6};
    vecs[6] = '{1'b0, 1'b1, 16'd0, 8'd0, 16'd0, 16'd0,  16'd1,  24'd6};
    exp6 = '{4, 24, 39, 49, 59, 74};

    rst = 1'b1; drv_enable_SM = 1'b1; move_req = 1'b0; move_dir = 1'b0;
    move_steps = '0; limit_fwd = 1'b0; limit_rev = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {sm_step, sm_dir, sm_en, busy, done, fault}, 0);
    chk("reset_pos", pos_u(), 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_rst) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      run_move(vecs[i].dir, vecs[i].steps, 0, -1, 300);
      chk($sformatf("v%0d_pulses", i), n_rise, int'(vecs[i].np));
      chk($sformatf("v%0d_done_cyc", i), done_cyc, int'(vecs[i].done_c));
      chk($sformatf("v%0d_fault", i), fault_cyc, -1);
      chk($sformatf("v%0d_pos", i), pos_u(), int'(vecs[i].pos));
      chk($sformatf("v%0d_end_idle", i), {busy_end, en_end, step_end}, 0);
      chk($sformatf("v%0d_done_fault_both", i), both_hi, 0);
      if (vecs[i].np != 0) begin
        chk($sformatf("v%0d_first_rise", i), rise_cyc[0], int'(vecs[i].first));
        chk($sformatf("v%0d_last_rise", i), rise_cyc[vecs[i].np - 1], int'(vecs[i].last));
        chk($sformatf("v%0d_start_outs", i), {busy_at1, en_at1, dir_at1}, {2'b11, vecs[i].dir});
      end else begin
        chk($sformatf("v%0d_no_busy", i), busy_at1, 0);
      end
      if (i == 1)
        for (int k = 0; k < 6; k++) chk($sformatf("v1_rise%0d", k), rise_cyc[k], exp6[k]);
      tick();
    end

    // reset mid-move while sm_step is high
    rst = 1'b1; tick(); rst = 1'b0;
    move_dir = 1'b1; move_steps = 16'd6; move_req = 1'b1;
    tick(); move_req = 1'b0;
    for (int c = 2; c <= 24; c++) tick();
    chk("pre_reset_step_high", sm_step, 1);
    rst = 1'b1; tick();
    chk("midreset_outputs", {sm_step, sm_dir, sm_en, busy, done, fault}, 0);
    chk("midreset_pos", pos_u(), 0);
    tick(); tick(); rst = 1'b0;
    watch_idle(40, r, a);
    chk("post_reset_rises", r, 0);
    chk("post_reset_activity", a, 0);

    // forward limit abort after the 2nd step
    run_move(1'b1, 16'd6, 1, -1, 300);
    chk("lim_abort_cyc", fault_cyc, 25);
    chk("lim_abort_outs", {step_end, busy_end, en_end}, 0);
    chk("lim_abort_pos", pos_u(), 2);
    chk("lim_abort_no_done", done_cyc, -1);
    watch_idle(30, r, a);
    chk("lim_abort_no_more_steps", r, 0);

    // limit still active: forward rejected, reverse allowed
    run_move(1'b1, 16'd3, 0, -1, 50);
    chk("lim_reject_cyc", fault_cyc, 1);
    chk("lim_reject_pulses", n_rise, 0);
    chk("lim_reject_busy", busy_at1, 0);
    chk("lim_reject_pos", pos_u(), 2);
    tick();
    run_move(1'b0, 16'd1, 0, -1, 100);
    chk("lim_rev_done", done_cyc, 24);
    chk("lim_rev_pos", pos_u(), 1);
    limit_fwd = 1'b0;
    tick();

    // enable drop abort
    run_move(1'b1, 16'd6, 2, -1, 300);
    chk("en_abort_cyc", fault_cyc, 25);
    chk("en_abort_outs", {step_end, busy_end, en_end}, 0);
    chk("en_abort_pos", pos_u(), 3);

    // request while disabled: nothing happens
    tick();
    run_move(1'b1, 16'd3, 0, -1, 30);
    chk("dis_req_done", done_cyc, -1);
    chk("dis_req_fault", fault_cyc, -1);
    chk("dis_req_pulses", n_rise, 0);
    chk("dis_req_busy", busy_at1, 0);
    chk("dis_req_pos", pos_u(), 3);
    drv_enable_SM = 1'b1;
    tick();

    // request while busy is ignored
    run_move(1'b1, 16'd2, 0, 10, 300);
    chk("busy_req_done", done_cyc, 39);
    chk("busy_req_pulses", n_rise, 2);
    chk("busy_req_fault", fault_cyc, -1);
    chk("busy_req_dir", dir_end, 1);
    chk("busy_req_pos", pos_u(), 5);
    watch_idle(30, r, a);
    chk("busy_req_no_requeue", r, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_step_gen.md
Name: sm_step_gen

Overview:
- Downstream stage of the tracking controller: turns move commands into step/dir/enable signals for the stepper-motor power driver.
- A command carries direction and step count. The block applies a linear accel/decel period ramp and meters physical step pulses.
- Maintains an absolute signed position count, honours limit switches, and aborts when the upstream enable drops.
- Runs on the 50 MHz system clock.

Parameters:
- STEP_HIGH, 50: sm_step high width in clk cycles (1 us).
- DIR_SETUP, 25: cycles from sm_dir/sm_en valid to the first sm_step rising edge.
- PERIOD_START, 5000: initial and final step period in cycles (rising edge to rising edge).
- PERIOD_MIN, 1000: cruise period floor; must be > STEP_HIGH.
- PERIOD_DEC, 100: period change per step while ramping.
- POS_W, 24: position counter width.

Ports:
- clk, in, 1: 50 MHz system clock.
- rst, in, 1: synchronous, active-high reset.
- drv_enable_SM, in, 1: motion permit from the tracking controller. Low blocks or aborts motion.
- move_req, in, 1: single-cycle command strobe.
- move_dir, in, 1: 1 = forward (position increments), 0 = reverse.
- move_steps, in, 16: number of steps to issue, unsigned.
- limit_fwd, in, 1: forward limit switch, active-high, already synchronised.
- limit_rev, in, 1: reverse limit switch, active-high, already synchronised.
- sm_step, out, 1: step pulse to the driver.
- sm_dir, out, 1: direction to the driver.
- sm_en, out, 1: driver enable.
- busy, out, 1: move in progress.
- done, out, 1: one-cycle pulse when a move completes normally.
- fault, out, 1: one-cycle pulse on a rejected or aborted move.
- position, out, POS_W: signed absolute step count.

Behaviour:
- Reset (sync, active-high, overrides everything including mid-move):
  - All outputs 0, position 0, state IDLE.
  - No partial pulse survives: sm_step is 0 in the cycle after rst is sampled high.
- IDLE state (busy = 0, sm_en = 0, sm_step = 0):
  - On move_req & drv_enable_SM:
    - move_steps == 0: done = 1 next cycle, no other change.
    - Limit active in the requested direction (limit_fwd when move_dir = 1, limit_rev when move_dir = 0): fault = 1 next cycle, stay IDLE.
    - Otherwise: latch move_dir and move_steps; period = PERIOD_START; ramp_cnt = 0; next cycle sm_dir = move_dir, sm_en = 1, busy = 1; enter SETUP.
  - move_req with drv_enable_SM = 0 is ignored; no fault pulse.
- SETUP: hold for DIR_SETUP cycles, then enter HIGH. With move_req at cycle 0, the first sm_step rising edge is at cycle 1 + DIR_SETUP.
- HIGH:
  - sm_step = 1 for STEP_HIGH cycles.
  - On the entry cycle: remaining -= 1, and position += 1 (forward) or -= 1 (reverse).
  - Position wraps modulo 2^POS_W, two's complement.
- LOW: sm_step = 0 for (period - STEP_HIGH) cycles. At the end of LOW, exactly one of:
  - remaining == 0: enter IDLE; done = 1, busy = 0, sm_en = 0 in that same cycle.
  - remaining <= ramp_cnt (decelerate): period = min(period + PERIOD_DEC, PERIOD_START); ramp_cnt -= 1; enter HIGH.
  - period > PERIOD_MIN (accelerate): period = max(period - PERIOD_DEC, PERIOD_MIN); ramp_cnt += 1; enter HIGH.
  - Otherwise cruise: enter HIGH unchanged.
- The updated period applies to the next step interval. Profile is symmetric; a short move peaks below cruise speed.
- Abort while busy (any state): drv_enable_SM = 0, or limit active in the latched direction.
  - Next cycle: sm_step = 0, sm_en = 0, busy = 0, fault = 1 for one cycle, state IDLE.
  - position keeps every step already counted in HIGH.
  - Abort takes priority over normal completion in the same cycle.
- move_req while busy is ignored; no queueing, no fault.
- done and fault are never both high.
- sm_dir holds its last value while IDLE.

Test Plan (sim parameters STEP_HIGH=2, DIR_SETUP=3, PERIOD_START=20, PERIOD_MIN=10, PERIOD_DEC=5, POS_W=24):
1. Reset: hold rst for 3 cycles mid-move -> all outputs 0, position 0 the cycle after rst is sampled; no further sm_step edges.
2. move_req at cycle 0, move_dir = 1, move_steps = 1, drv_enable_SM = 1:
   - sm_en/busy/sm_dir = 1 at cycle 1.
   - sm_step high at cycles 4-5.
   - done at cycle 24, position = 1.
3. move_steps = 6 forward, from position 0:
   - Rising edges at cycles 4, 24, 39, 49, 59, 74 (intervals 20, 15, 10, 10, 15, 20).
   - done at cycle 94, position = 6.
4. From position 6, move_dir = 0, move_steps = 3: sm_dir = 0, three pulses, final position = 3. Repeat from position 0 with move_steps = 1 reverse -> position = 0xFFFFFF (-1).
5. Limit and enable abort during a move of 6 forward:
   - limit_fwd raised after the 2nd rising edge -> sm_step = 0 next cycle, fault 1 cycle, busy = 0, position = 2.
   - With limit_fwd still high, a new forward request -> fault, no pulses; a reverse request proceeds normally.
   - drv_enable_SM dropped mid-move -> same abort response.
6. Command edge cases:
   - move_steps = 0 -> done at cycle 1, no pulses.
   - move_req with drv_enable_SM = 0 -> nothing.
   - move_req pulsed while busy -> ignored; the original move completes with its own step count.
